uart_parity_odd_tx: RTL and testbench
=====================================

// Module: uart_parity_odd_tx
// PURPOSE
//   Serial transmitter for the odd-parity UART link; the transmit end of uart_parity_odd.
//   Accepts parallel words over a valid/ready handshake and drives one line bit per clk.
//   Frame is start, data LSB-first, odd parity, then stop.
//   A one-word holding buffer allows back-to-back frames with no idle gap.
// PARAMETERS
//   DATA_W     8   data bits per frame
//   STOP_BITS  1   number of stop bits (>=1), each driven as 1
// PORTS
//   clk        in   1       system clock, all logic on posedge
//   reset      in   1       synchronous, active-high
//   in_data    in   DATA_W  word to transmit
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       block can accept a word this cycle
//   signal     out  1       serial line, registered; idle level 0
//   busy       out  1       a frame is on the line
//   frame_done out  1       1-cycle pulse during the last stop bit
// BEHAVIOUR
//   Reset is synchronous and active-high.
//   - While reset is high at a posedge: signal=0, busy=0, frame_done=0, buffer cleared, FSM=IDLE.
//   - in_ready is 0 while reset is high and 1 from the first cycle after release.
//   Frame format, one bit per clk cycle, length L = 2+DATA_W+STOP_BITS (11 at defaults):
//   - start bit = 1
//   - in_data[0] .. in_data[DATA_W-1]
//   - parity = ~^in_data, so data plus parity holds an odd count of ones
//   - STOP_BITS cycles of 1
//   - then 0 (idle), unless the next frame follows.
//   Handshake:
//   - A transfer occurs at a posedge where in_valid and in_ready are both 1.
//   - in_ready = !buf_full. It does not depend on in_valid; no combinational path from in_valid.
//   - in_data is sampled only on a transfer.
//   Latency: a word accepted at edge k while IDLE drives the start bit on signal from edge k.
//   - The data bit i appears from edge k+1+i.
//   - The parity bit appears from edge k+1+DATA_W.
//   FSM: IDLE -> START -> DATA (bit counter 0..DATA_W-1) -> PARITY -> STOP (counter 0..STOP_BITS-1).
//   - In IDLE, a transfer loads the shift register and moves to START.
//   - From START, DATA and PARITY the FSM always advances one state per cycle.
//   - At the end of STOP, if the buffer is full it moves to the shifter and the FSM enters START.
//     The new start bit immediately follows the last stop bit.
//   - At the end of STOP with the buffer empty, the FSM goes to IDLE (signal=0).
//   Buffer (1 entry):
//   - A transfer while the FSM is not IDLE writes the buffer.
//   - A transfer at the same edge the last stop bit ends, with the buffer empty, loads the shifter directly.
//     The next frame then starts back-to-back.
//   - Buffer full at end of frame: the buffer drains into the shifter, and in_ready rises the following cycle.
//   busy is 1 in START, DATA, PARITY and STOP, and 0 in IDLE.
//   - busy stays 1 across back-to-back frames.
//   frame_done is 1 exactly while the final stop bit of each frame is on signal.
//   Reset mid-frame:
//   - The frame is aborted and the buffered word is dropped.
//   - signal=0 from that edge.
//   - No frame_done pulse is produced for the aborted frame.
// TESTING
//   1. Reset, then send 0xA5 (4 ones).
//      -> signal 1, 1,0,1,0,0,1,0,1, 1 (parity), 1 (stop), then 0.
//      -> frame_done is high on the stop-bit cycle.
//   2. Send 0x07 (3 ones).
//      -> signal 1, 1,1,1,0,0,0,0,0, 0 (parity), 1, then 0.
//      -> busy is high for exactly 11 cycles.
//   3. Send 0x00 then 0xFF with in_valid held high.
//      -> The second word is accepted during the first frame, and in_ready=0 while the buffer is full.
//      -> 22 contiguous bits with no idle gap; both parity bits are 1.
//   4. With the buffer full, present 0x55 until it is accepted.
//      -> 0x55 is accepted one cycle after the first frame ends.
//      -> Third frame: 1, 1,0,1,0,1,0,1,0, 1, 1.
//   5. Assert reset while data bit 4 of 0x3C is on the line, with 0x81 buffered.
//      -> signal=0 and busy=0 from that edge, and frame_done stays 0.
//      -> After release the line idles at 0; 0x81 is never sent.
//   6. Loopback of signal into uart_parity_odd for words 0x00, 0x3C, 0xFF.
//      -> The receiver asserts valid once per frame with error=0.

Source files
------------

// File: rtl/uart_parity_odd_tx.sv
// Odd-parity UART transmitter.
// Frames are start(1), data LSB-first, parity (~^data), STOP_BITS x 1. The idle line level is 0.
// A one-word holding buffer lets the next frame start in the cycle right after the last stop bit.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | line at 0, waiting for a word
// S_START  | start bit (1) on the line
// S_DATA   | data bit r_cnt on the line (0..DATA_W-1)
// S_PARITY | odd parity bit on the line
// S_STOP   | stop bit r_cnt on the line (0..STOP_BITS-1)
module uart_parity_odd_tx #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              signal,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] r_buf;
    logic [DATA_W-1:0] w_buf_nxt;
    logic              r_buf_full;
    logic              w_buf_full_nxt;
    logic              r_par;
    logic              w_par_nxt;
    logic              r_sig;
    logic              w_sig_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_xfer;
    logic              w_last_data;
    logic              w_last_stop;

    // Ready depends only on buffer occupancy and reset, never on in_valid.
    assign in_ready    = !r_buf_full && !reset;
    assign w_xfer      = in_valid && in_ready;
    assign w_last_data = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_last_stop = (r_state == S_STOP) && (r_cnt == CNT_W'(STOP_BITS - 1));

    assign signal     = r_sig;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = w_last_stop;

    // Next-state, next line bit and buffer bookkeeping.
    // r_sig is loaded with the bit belonging to the state being entered,
    // so the line bit changes on the same edge as the state.
    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_buf_nxt      = r_buf;
        w_buf_full_nxt = r_buf_full;
        w_par_nxt      = r_par;
        w_sig_nxt      = r_sig;
        w_cnt_nxt      = r_cnt;

        case (r_state)
            S_IDLE: begin
                w_sig_nxt = 1'b0;
                if (w_xfer) begin
                    w_shift_nxt = in_data;
                    w_par_nxt   = ~^in_data;
                    w_sig_nxt   = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_sig_nxt   = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_last_data) begin
                    w_sig_nxt   = r_par;
                    w_state_nxt = S_PARITY;
                end else begin
                    w_sig_nxt   = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                w_sig_nxt   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (!w_last_stop) begin
                    w_sig_nxt = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else if (r_buf_full) begin
                    w_shift_nxt    = r_buf;
                    w_par_nxt      = ~^r_buf;
                    w_buf_full_nxt = 1'b0;
                    w_sig_nxt      = 1'b1;
                    w_state_nxt    = S_START;
                end else if (w_xfer) begin
                    // Word arriving on the last stop edge bypasses the buffer.
                    w_shift_nxt = in_data;
                    w_par_nxt   = ~^in_data;
                    w_sig_nxt   = 1'b1;
                    w_state_nxt = S_START;
                end else begin
                    w_sig_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_sig_nxt   = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Words taken mid-frame park in the holding buffer.
        if (w_xfer && (r_state != S_IDLE) && !w_last_stop) begin
            w_buf_nxt      = in_data;
            w_buf_full_nxt = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any frame and drops the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_par      <= 1'b0;
            r_sig      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_buf      <= w_buf_nxt;
            r_buf_full <= w_buf_full_nxt;
            r_par      <= w_par_nxt;
            r_sig      <= w_sig_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_parity_odd_tx.sv
// Directed bench for uart_parity_odd_tx: inputs driven and outputs sampled on negedge.
module tb_uart_parity_odd_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       signal;
    logic       busy;
    logic       frame_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    uart_parity_odd_tx #(
        .DATA_W    (8),
        .STOP_BITS (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .signal     (signal),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge while idle; returns at the negedge showing the start bit.
    task automatic send_word(input logic [7:0] d);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    // f[10] is the first bit on the line.
    task automatic check_frame(input string tag, input logic [10:0] f);
        int nbusy;
        nbusy = 0;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("%s bit%0d", tag, i), 32'(signal), 32'(f[10-i]));
            chk($sformatf("%s done%0d", tag, i), 32'(frame_done), 32'(i == 10));
            if (busy) nbusy++;
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            if (busy) nbusy++;
            if (i == 0) chk({tag, " idle"}, 32'(signal), 32'd0);
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, 32'(nbusy), 32'd11);
    endtask

    // Receiver model: finds a start bit then decodes data, parity and stop.
    task automatic rx_check(input string tag, input logic [7:0] exp_d);
        logic [7:0] d;
        logic       par;
        int         wait_n;
        wait_n = 0;
        while (signal !== 1'b1 && wait_n < 5) begin
            @(negedge clk);
            wait_n++;
        end
        chk({tag, " start_found"}, 32'(signal), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d[i] = signal;
        end
        @(negedge clk);
        par = signal;
        @(negedge clk);
        chk({tag, " stop"}, 32'(signal), 32'd1);
        chk({tag, " data"}, 32'(d), 32'(exp_d));
        chk({tag, " odd"}, 32'(^{par, d}), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [32:0] stream;
        logic [7:0]  wq [3];
        int          wi;
        int          acc55;
        logic        xfer;
        int          bad;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst signal", 32'(signal), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(frame_done), 32'd0);
        chk("rst ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst ready", 32'(in_ready), 32'd1);
        chk("post_rst signal", 32'(signal), 32'd0);

        // Single frames
        send_word(8'hA5);
        check_frame("a5", 11'b11010010111);
        send_word(8'h07);
        check_frame("07", 11'b11110000001);

        // Back-to-back 0x00, 0xFF, then 0x55 presented until taken
        stream = {11'b10000000011, 11'b11111111111, 11'b11010101011};
        wq[0] = 8'h00; wq[1] = 8'hFF; wq[2] = 8'h55;
        wi = 0; acc55 = -1;
        in_data = wq[0]; in_valid = 1'b1;
        for (int j = 0; j < 34; j++) begin
            xfer = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (xfer) begin
                if (wi == 2) acc55 = j;
                wi++;
                if (wi < 3) in_data = wq[wi];
                else in_valid = 1'b0;
            end
            @(negedge clk);
            if (j < 33) begin
                chk($sformatf("b2b bit%0d", j), 32'(signal), 32'(stream[32-j]));
                chk($sformatf("b2b busy%0d", j), 32'(busy), 32'd1);
                chk($sformatf("b2b done%0d", j), 32'(frame_done), 32'(j == 10 || j == 21 || j == 32));
                chk($sformatf("b2b ready%0d", j), 32'(in_ready), 32'(j == 0 || j == 11 || j >= 22));
            end else begin
                chk("b2b idle signal", 32'(signal), 32'd0);
                chk("b2b idle busy", 32'(busy), 32'd0);
            end
        end
        chk("b2b accept55_edge", 32'(acc55), 32'd12);

        // Reset while data bit 4 of 0x3C is on the line, 0x81 buffered
        @(negedge clk);
        in_data = 8'h3C; in_valid = 1'b1;
        @(posedge clk);
        #1 in_data = 8'h81;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("abort buf_full_ready", 32'(in_ready), 32'd0);
        chk("abort bit0", 32'(signal), 32'd0);
        repeat (4) @(negedge clk);
        chk("abort bit4", 32'(signal), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort signal", 32'(signal), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(frame_done), 32'd0);
        chk("abort ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (signal !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) bad++;
        end
        chk("abort quiet_after", 32'(bad), 32'd0);
        chk("abort ready_after", 32'(in_ready), 32'd1);

        // Receiver-model loopback
        send_word(8'h00);
        rx_check("rx00", 8'h00);
        send_word(8'h3C);
        rx_check("rx3c", 8'h3C);
        send_word(8'hFF);
        rx_check("rxff", 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
